reg_load_arbiter: RTL and testbench
===================================

REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, width of the register data path; NUM_REQ, default 4, number of requesters (2..8); LOCK_MAX, default 8, maximum consecutive locked grants.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req  input  NUM_REQ  per-requester load request.
REQ-006 req_lock  input  NUM_REQ  per-requester request to keep the grant.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 gnt  output  NUM_REQ  one-hot grant; data accepted in a cycle where req[i]&gnt[i].
REQ-009 load_c  output  1  registered load strobe to Register C.
REQ-010 data_in_c  output  DATA_WIDTH  registered data to Register C.
REQ-011 out_valid  output  1  Register C data_out_c holds a newly loaded value this cycle.
REQ-012 out_id  output  clog2(NUM_REQ)  index of the requester whose value is on data_out_c when out_valid=1.

Function
REQ-013 gnt SHALL be combinational from req, FSM state and the round-robin pointer, at most one bit set, and zero when req==0.
REQ-014 Round-robin: the search SHALL start at pointer ptr; after an accepted grant to index k, ptr SHALL become (k+1) mod NUM_REQ; ptr is unchanged in cycles with no grant.
REQ-015 FSM states: IDLE (no grant last cycle), GRANT (a single grant issued), LOCKED (grant held for the owner).
REQ-016 IDLE/GRANT -> GRANT on any grant; -> IDLE on req==0; GRANT -> LOCKED when the granted owner has req_lock=1 at acceptance.
REQ-017 In LOCKED the owner SHALL be granted exclusively while req[owner]=1 and req_lock[owner]=1, up to LOCK_MAX consecutive grants including the first.
REQ-018 LOCKED SHALL be left when the owner drops req or req_lock, or when the lock counter reaches LOCK_MAX; round-robin resumes in that same cycle from ptr=(owner+1) mod NUM_REQ.
REQ-019 An accepted grant in cycle t SHALL produce load_c=1 and data_in_c=req_data of the winner in cycle t+1; otherwise load_c=0 and data_in_c holds its previous value.
REQ-020 A 3-stage tag pipeline (valid, id) SHALL track loads: out_valid/out_id assert in cycle t+3 for an acceptance in cycle t, matching Register C's 2-stage output pipeline.
REQ-021 Back-to-back acceptances SHALL each produce exactly one out_valid pulse, in order, with no bubbles.
REQ-022 Requests that drop in the same cycle as a grant decision SHALL NOT be granted; gnt SHALL follow req in that cycle.

Reset
REQ-023 During reset: gnt=0 and state=IDLE; ptr, load_c, data_in_c, out_valid and out_id SHALL be 0; lock counter cleared.
REQ-024 Reset mid-lock or with loads in flight SHALL discard all pending tags; no out_valid SHALL appear after reset for loads accepted before it.

Configuration
REQ-025 With REG_ARB_LOCK_EN defined, LOCKED and the lock counter SHALL be implemented per REQ-016..018.
REQ-026 Without REG_ARB_LOCK_EN, req_lock SHALL be ignored, LOCKED SHALL be unreachable and the arbiter SHALL be pure round-robin; the port list SHALL be unchanged.

Structure
REQ-027 Package reg_arb_pkg SHALL hold the FSM state enum, the default LOCK_MAX and the tag pipeline depth constant (3).
REQ-028 One sub-module, rr_arbiter (req, ptr -> one-hot gnt, winner index), SHALL be instantiated for the round-robin search.

Verification
REQ-029 req=4'b1111 held for 8 cycles, lock off, ptr=0 -> grant sequence 0,1,2,3,0,1,2,3.
REQ-030 Single grant to req 2 with data 0xDEADBEEF in cycle 5 -> load_c=1 and data_in_c=0xDEADBEEF in cycle 6; out_valid=1 and out_id=2 in cycle 8, with data_out_c=0xDEADBEEF.
REQ-031 With REG_ARB_LOCK_EN, req 1 holds req and req_lock for 12 cycles while req 3 is also requesting -> 8 grants to 1, then a grant to 3.
REQ-032 Lock owner drops req_lock after 3 grants -> next cycle is granted round-robin starting at index 2.
REQ-033 Reset asserted one cycle after two back-to-back loads -> no out_valid pulses follow, and all outputs read 0.
REQ-034 Without the macro, req_lock=all ones with req=4'b0011 -> grants alternate 0,1,0,1.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and constants for the Register C load arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   LOCK_MAX_DEFAULT : default cap on consecutive locked grants
//   TAG_DEPTH        : depth of the (valid, id) tag pipeline; one stage for
//                      the load register plus two for Register C's output
// ---------------------------------------------------------------------------
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no grant issued last cycle
    ST_GRANT  = 2'd1,  // a single round-robin grant issued
    ST_LOCKED = 2'd2   // grant held for the lock owner
  } arb_state_e;

  localparam int LOCK_MAX_DEFAULT = 8;
  localparam int TAG_DEPTH        = 3;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin search: the first set bit of req at or after
// ptr (wrapping) wins.
// Ports:
//   req    [NUM_REQ]        request vector
//   ptr    [clog2(NUM_REQ)] index where the search starts
//   gnt    [NUM_REQ]        one-hot grant, zero when req == 0
//   winner [clog2(NUM_REQ)] index of the granted requester (0 when none)
//   found  1                a requester was selected
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       found
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    logic [IDX_W-1:0] sel;
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    sel    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sel = IDX_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[sel]) begin
        gnt[sel] = 1'b1;
        winner   = sel;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_load_arbiter.sv
// ---------------------------------------------------------------------------
// reg_load_arbiter
// Arbitrates NUM_REQ requesters for loads into Register C. The grant is
// combinational; the winner's data is registered onto load_c/data_in_c and a
// (valid, id) tag follows the load through a TAG_DEPTH-stage pipeline so that
// out_valid/out_id line up with Register C's data_out_c.
//
// Compile-time option:
//   REG_ARB_LOCK_EN  when defined, a requester holding req_lock keeps the
//                    grant for up to LOCK_MAX consecutive grants. When not
//                    defined, req_lock is ignored (pure round-robin).
//
// Ports:
//   clk        1                  rising-edge clock
//   reset      1                  synchronous active-high reset
//   req        NUM_REQ            per-requester load request
//   req_lock   NUM_REQ            per-requester request to keep the grant
//   req_data   NUM_REQ*DATA_WIDTH requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt        NUM_REQ            one-hot grant (combinational)
//   load_c     1                  registered load strobe to Register C
//   data_in_c  DATA_WIDTH         registered load data to Register C
//   out_valid  1                  data_out_c holds a newly loaded value
//   out_id     clog2(NUM_REQ)     requester whose value is on data_out_c
// ---------------------------------------------------------------------------
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LOCK_MAX   = LOCK_MAX_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          load_c,
  output logic [DATA_WIDTH-1:0]         data_in_c,
  output logic                          out_valid,
  output logic [$clog2(NUM_REQ)-1:0]    out_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_winner;
  logic               rr_found;

  logic               lock_hold;   // owner keeps the grant this cycle
  logic               lock_start;  // round-robin winner asks to lock
  logic [NUM_REQ-1:0] lock_gnt;
  logic [IDX_W-1:0]   lock_idx;

  logic [NUM_REQ-1:0]    gnt_sel;
  logic                  grant_vld;
  logic [IDX_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req    (req),
    .ptr    (ptr_reg),
    .gnt    (rr_gnt),
    .winner (rr_winner),
    .found  (rr_found)
  );

`ifdef REG_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [IDX_W-1:0] owner_reg, owner_next;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;

  // lock_cnt_reg counts grants already given to the owner, including the
  // round-robin grant that started the lock; once it reaches LOCK_MAX the
  // owner must re-compete from ptr = owner+1.
  assign lock_hold  = (state_reg == ST_LOCKED) && req[owner_reg] &&
                      req_lock[owner_reg] && (lock_cnt_reg < CNT_W'(LOCK_MAX));
  assign lock_start = !lock_hold && rr_found && req_lock[rr_winner];
  assign lock_gnt   = NUM_REQ'(1) << owner_reg;
  assign lock_idx   = owner_reg;

  always_comb begin
    owner_next    = owner_reg;
    lock_cnt_next = lock_cnt_reg;
    if (!grant_vld) begin
      lock_cnt_next = '0;
    end else if (lock_hold) begin
      lock_cnt_next = lock_cnt_reg + 1'b1;
    end else if (lock_start) begin
      owner_next    = rr_winner;
      lock_cnt_next = CNT_W'(1);
    end else begin
      lock_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_reg    <= '0;
      lock_cnt_reg <= '0;
    end else begin
      owner_reg    <= owner_next;
      lock_cnt_reg <= lock_cnt_next;
    end
  end
`else
  logic unused_lock;

  assign lock_hold   = 1'b0;
  assign lock_start  = 1'b0;
  assign lock_gnt    = '0;
  assign lock_idx    = '0;
  // Without locking the FSM state is informational only.
  assign unused_lock = ^{req_lock, state_reg};
`endif

  always_comb begin
    gnt_sel    = rr_gnt;
    win_idx    = rr_winner;
    grant_vld  = rr_found;
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (lock_hold) begin
      gnt_sel   = lock_gnt;
      win_idx   = lock_idx;
      grant_vld = 1'b1;
    end
    if (reset) begin
      gnt_sel   = '0;
      grant_vld = 1'b0;
    end
    // gnt is a subset of req, so every grant is an accepted transfer.
    if (grant_vld) begin
      ptr_next   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      state_next = (lock_hold || lock_start) ? ST_LOCKED : ST_GRANT;
    end else begin
      state_next = ST_IDLE;
    end
  end

  assign gnt = gnt_sel;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      load_c    <= 1'b0;
      data_in_c <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      load_c    <= grant_vld;
      if (grant_vld) begin
        data_in_c <= win_data;
      end
    end
  end

  // Tag pipeline: stage 0 sits beside load_c, the last stage lines up with
  // Register C's output. Reset flushes every stage.
  logic             tag_vld_reg [TAG_DEPTH];
  logic [IDX_W-1:0] tag_id_reg  [TAG_DEPTH];

  generate
    for (genvar gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
      logic             vld_in;
      logic [IDX_W-1:0] id_in;
      if (gi == 0) begin : g_head
        assign vld_in = grant_vld;
        assign id_in  = win_idx;
      end else begin : g_link
        assign vld_in = tag_vld_reg[gi-1];
        assign id_in  = tag_id_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_vld_reg[gi] <= 1'b0;
          tag_id_reg[gi]  <= '0;
        end else begin
          tag_vld_reg[gi] <= vld_in;
          tag_id_reg[gi]  <= id_in;
        end
      end
    end
  endgenerate

  assign out_valid = tag_vld_reg[TAG_DEPTH-1];
  assign out_id    = tag_id_reg[TAG_DEPTH-1];

endmodule

// File: tb/tb_reg_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_load_arbiter
// Directed bench for reg_load_arbiter (NUM_REQ=4, DATA_WIDTH=32, LOCK_MAX=8).
// A cycle-level model of the arbitration rules predicts gnt, load_c,
// data_in_c, out_valid and out_id every cycle; directed sequences pin the
// model with hand-computed grant orders and latencies. Lock scenarios run
// when REG_ARB_LOCK_EN is defined, the lock-ignored scenario otherwise.
// ---------------------------------------------------------------------------
module tb_reg_load_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int LM = 8;
`ifdef REG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_lock = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      gnt;
  logic              load_c;
  logic [DW-1:0]     data_in_c;
  logic              out_valid;
  logic [1:0]        out_id;

  int n_chk = 0;
  int n_err = 0;
  int seq   = 0;

  always #5 clk = ~clk;

  reg_load_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .LOCK_MAX   (LM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_lock  (req_lock),
    .req_data  (req_data),
    .gnt       (gnt),
    .load_c    (load_c),
    .data_in_c (data_in_c),
    .out_valid (out_valid),
    .out_id    (out_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int            m_ptr = 0;
  int            m_owner = 0;
  int            m_run = 0;      // consecutive grants held by m_owner
  logic [DW-1:0] m_data = '0;
  int            cyc = 0;
  bit            acc_v [0:2047];
  int            acc_id[0:2047];
  bit            rst_h [0:2047];
  int            gnt_log[$];

  function automatic bit rst_at(input int c);
    return (c < 0) ? 1'b1 : rst_h[c];
  endfunction

  function automatic bit acc_at(input int c);
    return (c < 0) ? 1'b0 : acc_v[c];
  endfunction

  always @(negedge clk) begin : cmp
    int           e;
    int           a;
    bit           hold;
    bit           ov;
    logic [N-1:0] eg;
    e    = -1;
    hold = 1'b0;
    if (!reset) begin
      if (LOCK_EN && m_run > 0 && m_run < LM && req[m_owner] && req_lock[m_owner]) begin
        e    = m_owner;
        hold = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          if (e < 0 && req[(m_ptr + k) % N]) e = (m_ptr + k) % N;
        end
      end
    end
    eg = (e < 0) ? '0 : (N'(1) << e);
    check("gnt", 64'(gnt), 64'(eg));
    a = -1;
    for (int k = 0; k < N; k++) if (gnt[k] === 1'b1) a = k;
    gnt_log.push_back(a);

    check("load_c", 64'(load_c), 64'(acc_at(cyc - 1)));
    check("data_in_c", 64'(data_in_c), 64'(m_data));
    ov = acc_at(cyc - 3) && !rst_at(cyc - 3) && !rst_at(cyc - 2) && !rst_at(cyc - 1);
    check("out_valid", 64'(out_valid), 64'(ov));
    if (ov) check("out_id", 64'(out_id), 64'(acc_id[cyc - 3]));
    if (rst_at(cyc - 1)) check("out_id_rst", 64'(out_id), 64'd0);

    rst_h[cyc]  = reset;
    acc_v[cyc]  = (e >= 0);
    acc_id[cyc] = e;
    if (reset) begin
      m_ptr  = 0;
      m_run  = 0;
      m_data = '0;
    end else if (e >= 0) begin
      m_data = req_data[e*DW +: DW];
      m_ptr  = (e + 1) % N;
      if (hold) m_run++;
      else if (LOCK_EN && req_lock[e]) begin
        m_owner = e;
        m_run   = 1;
      end else m_run = 0;
      $display("txn cyc=%0d grant=%0d data=%08h", cyc, e, m_data);
    end else begin
      m_run = 0;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic rs);
    @(posedge clk);
    #1;
    seq++;
    req      = r;
    req_lock = l;
    reset    = rs;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = (32'(i + 1) << 28) | 32'(seq);
  endtask

  // exp holds expected winner indices, one per nibble, first grant in bits [3:0]
  task automatic chk_log(input string name, input int base, input int cnt, input logic [63:0] exp);
    @(negedge clk);
    #1;
    for (int k = 0; k < cnt; k++) begin
      if (base + k < gnt_log.size())
        check(name, 64'(gnt_log[base + k]), 64'(exp[k*4 +: 4]));
      else
        check(name, 64'hFFFF, 64'(exp[k*4 +: 4]));
    end
  endtask

  logic [N-1:0] tbl_req [12] = '{4'b1010, 4'b0110, 4'b0000, 4'b1001, 4'b1111, 4'b0001,
                                 4'b0100, 4'b1100, 4'b0011, 4'b1110, 4'b0000, 4'b1000};
  logic [N-1:0] tbl_lck [12] = '{4'b0010, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                                 4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0000};

  initial begin : stim
    int base;
    // reset state, with requests present
    repeat (2) @(posedge clk);
    #1;
    req = 4'b1111;
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_load_c", 64'(load_c), 64'd0);
    check("rst_data_in_c", 64'(data_in_c), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);

    // round robin over all four from ptr=0
    drive(4'b1111, 4'b0000, 1'b0);
    base = gnt_log.size();
    repeat (7) drive(4'b1111, 4'b0000, 1'b0);
    chk_log("rr_all", base, 8, 64'h3210_3210);
    drive(4'b0000, 4'b0000, 1'b0);

    // single load latency: acceptance in t, load in t+1, tag in t+3
    drive(4'b0100, 4'b0000, 1'b0);
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    drive(4'b0000, 4'b0000, 1'b0);
    check("lat_load_c", 64'(load_c), 64'd1);
    check("lat_data_in_c", 64'(data_in_c), 64'hDEADBEEF);
    drive(4'b0000, 4'b0000, 1'b0);
    check("lat_load_c_off", 64'(load_c), 64'd0);
    check("lat_out_valid_early", 64'(out_valid), 64'd0);
    drive(4'b0000, 4'b0000, 1'b0);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_id", 64'(out_id), 64'd2);
    check("lat_data_hold", 64'(data_in_c), 64'hDEADBEEF);

`ifdef REG_ARB_LOCK_EN
    // requester 1 locks for LOCK_MAX grants, then requester 3 gets a turn
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b1010, 4'b0010, 1'b0);
    base = gnt_log.size();
    repeat (11) drive(4'b1010, 4'b0010, 1'b0);
    chk_log("lock_max", base, 9, 64'h3_1111_1111);
    drive(4'b0000, 4'b0000, 1'b0);

    // owner drops req_lock after 3 grants; round robin resumes at 2
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b1110, 4'b0010, 1'b0);
    base = gnt_log.size();
    drive(4'b1111, 4'b0010, 1'b0);
    drive(4'b1111, 4'b0010, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0);
    chk_log("lock_drop", base, 4, 64'h2111);
    drive(4'b0000, 4'b0000, 1'b0);
`else
    // req_lock ignored: two requesters alternate
    drive(4'b0011, 4'b1111, 1'b0);
    base = gnt_log.size();
    repeat (3) drive(4'b0011, 4'b1111, 1'b0);
    chk_log("nolock_alt", base, 4, 64'h1010);
    drive(4'b0000, 4'b0000, 1'b0);
`endif

    // mixed vectors, checked by the model only
    for (int i = 0; i < 12; i++) drive(tbl_req[i], tbl_lck[i], 1'b0);
    drive(4'b0000, 4'b0000, 1'b0);

    // reset one cycle after two back-to-back loads discards their tags
    drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b0010, 4'b0000, 1'b0);
    drive(4'b0000, 4'b0000, 1'b1);
    drive(4'b0000, 4'b0000, 1'b0);
    check("flush_load_c", 64'(load_c), 64'd0);
    check("flush_data_in_c", 64'(data_in_c), 64'd0);
    check("flush_out_id", 64'(out_id), 64'd0);
    check("flush_out_valid0", 64'(out_valid), 64'd0);
    for (int i = 1; i < 4; i++) begin
      drive(4'b0000, 4'b0000, 1'b0);
      check("flush_out_valid", 64'(out_valid), 64'd0);
    end

    repeat (4) drive(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
